// File: rtl/shift_pkg.sv
// Shared types for the barrel-shift pipeline: operation codes, the S1 command
// record and the legality check for op codes.
package shift_pkg;

  localparam int SHIFT_WIDTH = 8;
  localparam int SHIFT_AMT_W = $clog2(SHIFT_WIDTH);

  typedef enum logic [2:0] {
    OP_ROR = 3'd0,
    OP_ROL = 3'd1,
    OP_SHR = 3'd2,
    OP_SHL = 3'd3,
    OP_ASR = 3'd4
  } shift_op_t;

  // op is kept as raw bits so illegal codes 5..7 survive to the shifter
  typedef struct packed {
    logic [SHIFT_WIDTH-1:0] data;
    logic [SHIFT_AMT_W-1:0] amt;
    logic [2:0]             op;
  } shift_cmd_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= OP_ASR;
  endfunction

endpackage

// File: rtl/shift_core.sv
// Purely combinational log2 barrel shifter: AMT_W mux stages, stage k moving
// by 2^k. Left rotates are folded into right rotates by the negated amount.
module shift_core
  import shift_pkg::*;
#(
  parameter int  WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  logic             legal;
  logic             rotate;
  logic             left;
  logic             fill_bit;
  logic [AMT_W-1:0] eff_amt;
  logic [WIDTH-1:0] stage [AMT_W+1];

  // Negating the amount modulo WIDTH turns ROL into ROR.
  always_comb begin
    legal    = is_legal_op(op);
    rotate   = (op == OP_ROR) || (op == OP_ROL);
    left     = (op == OP_SHL);
    fill_bit = (op == OP_ASR) ? data[WIDTH-1] : 1'b0;
    eff_amt  = (op == OP_ROL) ? -amt : amt;
  end

  assign stage[0] = data;

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    localparam int S = 1 << k;
    logic [S-1:0]     wrap;
    logic [WIDTH-1:0] moved_r;
    logic [WIDTH-1:0] moved_l;

    assign wrap    = rotate ? stage[k][S-1:0] : {S{fill_bit}};
    assign moved_r = {wrap, stage[k][WIDTH-1:S]};
    assign moved_l = {stage[k][WIDTH-S-1:0], {S{1'b0}}};
    assign stage[k+1] = !eff_amt[k] ? stage[k] : (left ? moved_l : moved_r);
  end

  assign result = legal ? stage[AMT_W] : data;
  assign err    = !legal;

endmodule

// File: rtl/rotate_shift_pipe.sv
// Two-register valid/ready wrapper around shift_core: S1 holds the command,
// S2 holds the result; full backpressure with no skid buffer.
module rotate_shift_pipe
  import shift_pkg::*;
#(
  // The S1 record is sized from the package, so WIDTH must equal SHIFT_WIDTH.
  parameter int  WIDTH = SHIFT_WIDTH,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_err
);

  logic             s1_valid;
  shift_cmd_t       s1_cmd;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic             s2_zero;
  logic             s2_err;
  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] core_result;
  logic             core_err;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cmd   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_cmd <= '{data: in_data, amt: in_amt, op: in_op};
      end
    end
  end

  shift_core #(.WIDTH(WIDTH)) u_core (
    .data   (s1_cmd.data),
    .amt    (s1_cmd.amt),
    .op     (s1_cmd.op),
    .result (core_result),
    .err    (core_err)
  );

  // S2 payload only loads on a real transfer, so a stalled result stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_zero  <= 1'b0;
      s2_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= core_result;
        s2_zero <= (core_result == '0);
        s2_err  <= core_err;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_zero  = s2_zero;
  assign out_err   = s2_err;

endmodule

// File: doc/rotate_shift_pipe.md
Name: rotate_shift_pipe

Overview:
- Registered, handshaked front-end for the 8-bit barrel-shift datapath.
- Accepts {data, amount, op} over valid/ready and performs rotate-right, rotate-left, logical or arithmetic shift using a log2 mux-stage shifter core.
- Returns results over valid/ready with full backpressure, two pipeline registers and one result per cycle sustained.
- Sits between the command source and result consumer wherever the combinational shifter would otherwise sit on an unregistered path.

Parameters:
- WIDTH, 8, data width; must be a power of 2 and >= 2.
- AMT_W, $clog2(WIDTH), shift-amount width; localparam derived from WIDTH, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  command valid.
- in_ready  out  1  stage can accept a command this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  AMT_W  shift/rotate amount, 0..WIDTH-1.
- in_op  in  3  operation code (shift_op_t).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_zero  out  1  out_data == 0.
- out_err  out  1  the command carried an illegal op code.

Behaviour:
- Reset, asynchronous on rst_n low:
  - s1_valid=0, s2_valid=0.
  - out_valid=0, out_data=0, out_zero=0, out_err=0.
  - in_ready=1 from the first cycle after release.
  - Reset mid-operation discards every in-flight command; nothing is replayed.
- Pipeline:
  - S1 registers {in_data, in_amt, in_op} on the in_valid && in_ready edge.
  - The shifter core operates combinationally on the S1 registers.
  - S2 registers the result, zero flag and error flag.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, which is combinational from out_ready; no skid buffer.
  - Transfers occur only when valid && ready on the same edge.
  - out_valid=1 when s2_valid=1.
  - While out_valid=1 and out_ready=0, out_data, out_zero and out_err hold stable.
  - in_data, in_amt and in_op are ignored when in_valid=0.
- Latency and throughput:
  - A command accepted at edge N presents out_valid=1 after edge N+1.
  - With out_ready held at 1, one result per cycle, no bubbles.
- Simultaneous events:
  - S2 drains on the same edge it is refilled from S1.
  - S1 drains to S2 on the same edge it accepts a new command.
  - Result and command order is strictly preserved.
- Operations (amt = a):
  - ROR=0: rotate right by a.
  - ROL=1: rotate left by a, implemented as rotate right by (WIDTH-a) mod WIDTH.
  - SHR=2: logical right shift, zero fill.
  - SHL=3: logical left shift, zero fill.
  - ASR=4: arithmetic right shift, fill with data[WIDTH-1].
  - Codes 5..7 are illegal: out_data = operand unchanged, out_err=1. out_err=0 for all legal ops.
- Width and arithmetic rules:
  - Amount 0 returns the operand unchanged for every legal op.
  - Amount is never >= WIDTH by construction; no clamping logic.
  - Shifter core: AMT_W cascaded mux stages. Stage k moves by 2^k when amt[k]=1, fill per op. No multiplier, no variable-index part-select.
- Bubbles: a cycle with in_valid=0 leaves s1_valid=0 after the edge (if S1 advanced). out_valid drops only after S2 drains with no replacement.

Decomposition:
- Package shift_pkg:
  - typedef enum logic [2:0] shift_op_t {OP_ROR, OP_ROL, OP_SHR, OP_SHL, OP_ASR}.
  - Function is_legal_op.
  - Typedef struct shift_cmd_t {data, amt, op} used for the S1 register.
- Sub-module shift_core (purely combinational): inputs data, amt, op; outputs result, err.
  - Instantiated once between S1 and S2 so it can be exhaustively checked in isolation.
- The top level owns only the two stage registers and the handshake logic.

Test Plan:
- Reset then single command: data=0xB1, amt=3, ROR, out_ready=1 -> out_valid after edge N+1, out_data=0x36, out_zero=0, out_err=0.
- Op sweep on data=0x96, amt=2:
  - ROR -> 0xA5
  - ROL -> 0x5A
  - SHR -> 0x25
  - SHL -> 0x58
  - ASR -> 0xE5
  - op=6 -> 0x96 with out_err=1.
  - SHR 0x01 amt=1 -> 0x00 with out_zero=1.
- Back-to-back streaming: 16 commands on consecutive cycles with out_ready=1 -> 16 results on consecutive cycles, in order, no gaps, in_ready constantly 1.
- Backpressure: out_ready=0 for 5 cycles after 3 commands offered:
  - in_ready falls after two entries fill.
  - out_data holds the first result stable.
  - On release, results drain in order with no loss or duplication.
- Reset mid-flight: assert rst_n=0 with S1 and S2 both full -> out_valid=0 and out_data=0 immediately (asynchronous). No stale result appears after release.
- Exhaustive: all 256 data × 8 amounts × 8 ops through random valid/out_ready toggling -> every result matches the reference model, order preserved.
